// File: rtl/div32u_seq.sv
// Sequential unsigned 32/16 restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional remainder port R is enabled with `define DIV_REM_EN.
module div32u_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] O,
`ifdef DIV_REM_EN
  output logic [15:0] R,
`endif
  output logic        div_by_zero,
  output logic        overflow
);

  localparam int unsigned VW = 16;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state, state_next;
  logic [VW-1:0] div_q;
  logic [VW-1:0] dvd;
  logic [VW-1:0] rem;
  logic [CW-1:0] cnt;

  logic          accept_c;
  logic          zero_c;
  logic          ovf_c;
  logic [VW:0]   trial_c;
  logic          take_c;
  logic [VW-1:0] diff_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state plus the shared compare/subtract for one restoring step
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    zero_c     = (B == '0);
    ovf_c      = !zero_c && (A[31:16] >= B);
    trial_c    = {rem, dvd[VW-1]};
    take_c     = (trial_c >= {1'b0, div_q});
    // r < B guarantees t - B fits in 16 bits, so the low half is exact
    diff_c     = trial_c[VW-1:0] - div_q;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = (zero_c || ovf_c) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt == '0) state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs follow the next state so they are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
    end
  end

  // Datapath: capture on accept, one shift/subtract per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      dvd         <= '0;
      rem         <= '0;
      cnt         <= '0;
      O           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept_c) begin
      div_q       <= B;
      dvd         <= A[15:0];
      cnt         <= CW'(VW - 1);
      div_by_zero <= zero_c;
      overflow    <= ovf_c;
      if (zero_c || ovf_c) begin
        O   <= '1;
        rem <= A[15:0];
      end else begin
        O   <= '0;
        rem <= A[31:16];
      end
    end else if (state == S_BUSY) begin
      rem <= take_c ? diff_c : trial_c[VW-1:0];
      O   <= {O[VW-2:0], take_c};
      dvd <= {dvd[VW-2:0], 1'b0};
      cnt <= cnt - CW'(1);
    end
  end

`ifdef DIV_REM_EN
  assign R = rem;
`endif

endmodule
